// File: rtl/adc_capture_pkg.sv
// Shared types and default timing for the serial ADC capture front-end.
package adc_capture_pkg;

    // Frame sequencer states.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSetup = 3'd1,
        StShift = 3'd2,
        StDone  = 3'd3,
        StQuiet = 3'd4
    } state_e;

    // Default timing, in clk cycles.
    localparam int unsigned DEFAULT_CLK_DIV  = 4;
    localparam int unsigned DEFAULT_CS_SETUP = 2;
    localparam int unsigned DEFAULT_CS_HOLD  = 4;

    // Number of samples in the running mean (optional averaging build).
    localparam int unsigned AVG_DEPTH = 4;

endpackage

// File: rtl/adc_sclk_gen.sv
// ADC serial clock generator: CLK_DIV-cycle high phase followed by a CLK_DIV-cycle
// low phase, repeating while enabled. 'enable' is the next-cycle enable so that adclk
// can be registered and is high in the very first enabled cycle.
module adc_sclk_gen
    import adc_capture_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic adclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

    logic       en_q;
    logic [7:0] div_q, div_d;
    logic       low_q, low_d;     // 0: high phase, 1: low phase
    logic       adclk_q, adclk_d;
    logic       phase_end;

    // Divider and phase sequencing; phase restarts high whenever the clock is idle.
    always_comb begin
        div_d     = div_q;
        low_d     = low_q;
        phase_end = en_q && (div_q == DivLast);
        if (!en_q) begin
            div_d = '0;
            low_d = 1'b0;
        end else if (phase_end) begin
            div_d = '0;
            low_d = ~low_q;
        end else begin
            div_d = div_q + 8'd1;
        end
        adclk_d = enable && !low_d;
    end

    assign fall_tick = phase_end && !low_q;  // last cycle of high phase: sample strobe
    assign rise_tick = phase_end && low_q;   // last cycle of low phase: bit boundary
    assign adclk     = adclk_q;

    // Divider state and registered (glitch-free) serial clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q    <= 1'b0;
            div_q   <= '0;
            low_q   <= 1'b0;
            adclk_q <= 1'b0;
        end else begin
            en_q    <= enable;
            div_q   <= div_d;
            low_q   <= low_d;
            adclk_q <= adclk_d;
        end
    end

endmodule

// File: rtl/adc_serial_capture.sv
// Serial ADC capture: frames one conversion per start pulse (cs_n, adclk), shifts
// ad_in in MSB-first and presents the word with a one-cycle data_valid strobe.
// Optional build macro ADC_CAPTURE_AVG_EN: data becomes the mean of the last
// AVG_DEPTH captured samples instead of the raw sample.
module adc_serial_capture
    import adc_capture_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned LEAD_BITS = 0,
    parameter int unsigned CLK_DIV   = DEFAULT_CLK_DIV,
    parameter int unsigned CS_SETUP  = DEFAULT_CS_SETUP,
    parameter int unsigned CS_HOLD   = DEFAULT_CS_HOLD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ad_in,
    output logic              adclk,
    output logic              cs_n,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned        NBITS     = LEAD_BITS + DATA_W;
    localparam int unsigned        BitCntW   = $clog2(NBITS + 1);
    localparam logic [BitCntW-1:0] BitLast   = BitCntW'(NBITS);
    localparam logic [7:0]         SetupLast = 8'(CS_SETUP - 1);
    // The DONE cycle counts toward the hold time, so QUIET lasts CS_HOLD-1 cycles.
    localparam bit                 HasQuiet  = (CS_HOLD > 1);
    localparam logic [7:0]         QuietLast = HasQuiet ? 8'(CS_HOLD - 2) : 8'd0;

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   result;
    logic                data_valid_q;
    logic                cs_n_q, cs_n_d;
    logic                frame_end;
    logic                shift_en;
    logic                rise_tick, fall_tick;

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .enable    (shift_en),
        .adclk     (adclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // Frame sequencing, counters and shift register next-state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        frame_end = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSetup;
                    cnt_d   = '0;
                end
            end
            StSetup: begin
                if (cnt_q == SetupLast) begin
                    state_d   = StShift;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StShift: begin
                // Leading bits fall off the top of the register once the data bits arrive.
                if (fall_tick) begin
                    shift_d   = {shift_q[DATA_W-2:0], ad_in};
                    bit_cnt_d = bit_cnt_q + BitCntW'(1);
                end
                // Frame closes at the end of the last bit's low phase.
                if (rise_tick && (bit_cnt_q == BitLast)) begin
                    frame_end = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone: begin
                cnt_d = '0;
                if (HasQuiet) begin
                    state_d = StQuiet;
                end else begin
                    state_d = StIdle;
                end
            end
            StQuiet: begin
                if (cnt_q == QuietLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        shift_en = (state_d == StShift);
        cs_n_d   = !((state_d == StSetup) || (state_d == StShift));
        data_d   = frame_end ? result : data_q;
    end

`ifdef ADC_CAPTURE_AVG_EN
    // Previous AVG_DEPTH-1 raw samples; the current sample completes the window.
    logic [DATA_W-1:0] hist_q [AVG_DEPTH-1];
    logic [DATA_W+1:0] sum;

    // Mean of the current sample and history; accumulator sized for AVG_DEPTH = 4.
    always_comb begin
        sum = {2'b00, shift_q};
        for (int i = 0; i < int'(AVG_DEPTH) - 1; i++) begin
            sum = sum + {2'b00, hist_q[i]};
        end
        result = sum[DATA_W+1:2];
    end

    // History shifts once per completed frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(AVG_DEPTH) - 1; i++) begin
                hist_q[i] <= '0;
            end
        end else if (frame_end) begin
            hist_q[0] <= shift_q;
            for (int i = 1; i < int'(AVG_DEPTH) - 1; i++) begin
                hist_q[i] <= hist_q[i-1];
            end
        end
    end
`else
    assign result = shift_q;
`endif

    // Sequencer state and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            cs_n_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_valid_q <= frame_end;
            cs_n_q       <= cs_n_d;
        end
    end

    assign cs_n       = cs_n_q;
    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign busy       = (state_q != StIdle);
    assign overrun    = start && busy;

endmodule

// File: tb/tb_adc_serial_capture.sv
// Bench for adc_serial_capture: three instances (defaults, LEAD_BITS=2, fast timing),
// each fed by a behavioural ADC that shifts out a word MSB-first on adclk rises.
`timescale 1ns/1ps
module tb_adc_serial_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start_v = '0;
    wire  [2:0]  ad_in_v;
    wire  [2:0]  adclk_v, cs_n_v, dv_v, busy_v, ovr_v;
    wire  [15:0] data_v [3];
    logic [31:0] stream_m [3];
    int          nbits_m [3];
    logic [15:0] hist [3][3];
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    adc_serial_capture dut_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .ad_in(ad_in_v[0]), .adclk(adclk_v[0]),
        .cs_n(cs_n_v[0]), .data(data_v[0]), .data_valid(dv_v[0]), .busy(busy_v[0]),
        .overrun(ovr_v[0])
    );
    adc_serial_capture #(.LEAD_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .ad_in(ad_in_v[1]), .adclk(adclk_v[1]),
        .cs_n(cs_n_v[1]), .data(data_v[1]), .data_valid(dv_v[1]), .busy(busy_v[1]),
        .overrun(ovr_v[1])
    );
    adc_serial_capture #(.CLK_DIV(1), .CS_SETUP(1)) dut_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .ad_in(ad_in_v[2]), .adclk(adclk_v[2]),
        .cs_n(cs_n_v[2]), .data(data_v[2]), .data_valid(dv_v[2]), .busy(busy_v[2]),
        .overrun(ovr_v[2])
    );

    // Behavioural ADC: bit n of the stream appears after the n-th adclk rise of a frame.
    for (genvar g = 0; g < 3; g++) begin : g_adc
        int rcnt = 0;
        always @(posedge adclk_v[g] or posedge cs_n_v[g]) begin
            if (cs_n_v[g]) rcnt <= 0;
            else           rcnt <= rcnt + 1;
        end
        assign ad_in_v[g] = (rcnt >= 1 && rcnt <= nbits_m[g]) ?
                            stream_m[g][nbits_m[g] - rcnt] : 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 3; i++) hist[d][i] = '0;
    endtask

    // Expected data word for the next capture on instance d.
    task automatic model_word(input int d, input logic [15:0] raw, output logic [15:0] exp);
`ifdef ADC_CAPTURE_AVG_EN
        logic [17:0] sum;
        sum = 18'(raw) + 18'(hist[d][0]) + 18'(hist[d][1]) + 18'(hist[d][2]);
        exp = sum[17:2];
`else
        exp = raw;
`endif
        hist[d][2] = hist[d][1];
        hist[d][1] = hist[d][0];
        hist[d][0] = raw;
    endtask

    // One start pulse at relative cycle 0; observes the whole frame and the quiet tail.
    task automatic run_frame(input int d, input logic [31:0] stream, input int nbits,
                             input logic [15:0] raw, input int lat, input int first_rise);
        int          dv_cnt = 0, dv_at = -1, rises = 0, rise_at = -1, lo_first = -1;
        int          lo_last = -1;
        logic        prev_ck = 1'b0;
        logic [15:0] exp, got;
        got = '0;
        stream_m[d] = stream;
        nbits_m[d]  = nbits;
        model_word(d, raw, exp);
        @(posedge clk); #1;
        start_v[d] = 1'b1;
        for (int k = 0; k <= lat + 8; k++) begin
            @(negedge clk);
            if (adclk_v[d] && !prev_ck) begin
                rises++;
                if (rise_at < 0) rise_at = k;
            end
            prev_ck = adclk_v[d];
            if (!cs_n_v[d]) begin
                if (lo_first < 0) lo_first = k;
                lo_last = k;
            end
            if (dv_v[d]) begin
                dv_cnt++;
                dv_at = k;
                got   = data_v[d];
            end
            @(posedge clk); #1;
            start_v[d] = 1'b0;
        end
        check($sformatf("dut%0d valid_cycle", d), dv_at, lat);
        check($sformatf("dut%0d valid_count", d), dv_cnt, 1);
        check($sformatf("dut%0d data", d), {16'h0, got}, {16'h0, exp});
        check($sformatf("dut%0d adclk_rises", d), rises, nbits);
        check($sformatf("dut%0d first_rise", d), rise_at, first_rise);
        check($sformatf("dut%0d cs_n_first_low", d), lo_first, 1);
        check($sformatf("dut%0d cs_n_last_low", d), lo_last, lat - 1);
        check($sformatf("dut%0d idle_after", d), {31'h0, busy_v[d]}, 0);
        check($sformatf("dut%0d data_held", d), {16'h0, data_v[d]}, {16'h0, exp});
    endtask

    typedef struct {
        int          d;
        logic [31:0] stream;
        int          nbits;
        logic [15:0] raw;
        int          lat;
        int          first_rise;
    } vec_t;

    vec_t tbl [5];

`ifdef ADC_CAPTURE_AVG_EN
    logic [15:0] avg_exp [4] = '{16'h0040, 16'h00C0, 16'h0180, 16'h0280};
`endif

    initial begin
        logic [15:0] exp0;
        int          dv_cnt;
        int          dv_at;
        logic [15:0] ramp [4] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};

        tbl[0] = '{0, 32'h0000_A5C3, 16, 16'hA5C3, 131, 3};
        tbl[1] = '{1, 32'h0003_1234, 18, 16'h1234, 147, 3};
        tbl[2] = '{2, 32'h0000_0000, 16, 16'h0000,  34, 2};
        tbl[3] = '{2, 32'h0000_FFFF, 16, 16'hFFFF,  34, 2};
        tbl[4] = '{0, 32'h0000_5A3C, 16, 16'h5A3C, 131, 3};
        for (int d = 0; d < 3; d++) begin
            stream_m[d] = '0;
            nbits_m[d]  = 0;
        end
        clear_model();

        // Reset values on every instance.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst dut%0d cs_n", d), {31'h0, cs_n_v[d]}, 1);
            check($sformatf("rst dut%0d adclk", d), {31'h0, adclk_v[d]}, 0);
            check($sformatf("rst dut%0d data", d), {16'h0, data_v[d]}, 0);
            check($sformatf("rst dut%0d valid", d), {31'h0, dv_v[d]}, 0);
            check($sformatf("rst dut%0d busy", d), {31'h0, busy_v[d]}, 0);
            check($sformatf("rst dut%0d overrun", d), {31'h0, ovr_v[d]}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed frames.
        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i].d, tbl[i].stream, tbl[i].nbits, tbl[i].raw, tbl[i].lat,
                      tbl[i].first_rise);
        end

        // Overrun: re-starts at 50 (SHIFT) and 133 (QUIET) ignored, start at 135 accepted.
        stream_m[0] = 32'h0000_0F0F;
        nbits_m[0]  = 16;
        model_word(0, 16'h0F0F, exp0);
        dv_cnt = 0;
        dv_at  = -1;
        @(posedge clk); #1;
        start_v[0] = 1'b1;
        for (int k = 0; k <= 140; k++) begin
            @(negedge clk);
            check($sformatf("ovr k=%0d", k), {31'h0, ovr_v[0]}, (k == 50 || k == 133) ? 1 : 0);
            if (dv_v[0]) begin
                dv_cnt++;
                dv_at = k;
                check("ovr data", {16'h0, data_v[0]}, {16'h0, exp0});
            end
            if (k == 136) begin
                check("restart busy", {31'h0, busy_v[0]}, 1);
                check("restart cs_n", {31'h0, cs_n_v[0]}, 0);
            end
            @(posedge clk); #1;
            start_v[0] = (k + 1 == 50 || k + 1 == 133 || k + 1 == 135);
        end
        check("ovr valid_count", dv_cnt, 1);
        check("ovr valid_cycle", dv_at, 131);
        model_word(0, 16'h0F0F, exp0);
        dv_at = -1;
        for (int k = 141; k <= 280; k++) begin
            @(negedge clk);
            if (dv_v[0] && dv_at < 0) begin
                dv_at = k;
                check("restart data", {16'h0, data_v[0]}, {16'h0, exp0});
            end
        end
        check("restart valid_cycle", dv_at, 266);

        // Asynchronous reset mid-SHIFT at 60, released at 70; fresh capture afterwards.
        stream_m[0] = 32'h0000_FFFF;
        nbits_m[0]  = 16;
        dv_cnt = 0;
        @(posedge clk); #1;
        start_v[0] = 1'b1;
        for (int k = 0; k < 80; k++) begin
            if (k == 60) begin
                #2;
                rst = 1'b1;
                #1;
                check("abort cs_n", {31'h0, cs_n_v[0]}, 1);
                check("abort adclk", {31'h0, adclk_v[0]}, 0);
                check("abort busy", {31'h0, busy_v[0]}, 0);
                clear_model();
            end
            if (k == 70) begin
                #2;
                rst = 1'b0;
            end
            @(negedge clk);
            if (k == 59) begin
                check("pre-abort cs_n", {31'h0, cs_n_v[0]}, 0);
                check("pre-abort adclk", {31'h0, adclk_v[0]}, 1);
            end
            if (dv_v[0]) dv_cnt++;
            @(posedge clk); #1;
            start_v[0] = 1'b0;
        end
        check("abort valid_count", dv_cnt, 0);
        check("abort data", {16'h0, data_v[0]}, 0);
        run_frame(0, 32'h0000_FFFF, 16, 16'hFFFF, 131, 3);

        // Ramp from a clean reset (running mean in the averaging build).
        @(posedge clk); #2;
        rst = 1'b1;
        clear_model();
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_frame(0, {16'h0, ramp[i]}, 16, ramp[i], 131, 3);
`ifdef ADC_CAPTURE_AVG_EN
            check($sformatf("avg %0d", i), {16'h0, data_v[0]}, {16'h0, avg_exp[i]});
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
